// File: rtl/nios_pio_in_debounce_irq.sv
// Avalon-MM input PIO with synchroniser, per-bit debounce and edge-capture IRQ.
// Optional raw synchronised read at address 1: define NIOS_PIO_IN_RAW_READ_EN.
module nios_pio_in_debounce_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_w1c;
    logic             w_wr;
    logic [31:0]      w_rd;
    logic [31:0]      r_readdata;
    logic             r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            logic [WIDTH-1:0] r_deb;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_deb <= '0;
                end else begin
                    r_deb <= w_sync;
                end
            end
            assign w_deb = r_deb;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [CW-1:0] r_cnt;
                logic          r_deb;
                // Any return to the debounced level restarts the count.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_cnt <= '0;
                        r_deb <= 1'b0;
                    end else if (w_sync[i] == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST) begin
                        r_deb <= w_sync[i];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                assign w_deb[i] = r_deb;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_deb;
        end
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = ~r_prev & w_deb;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = r_prev & ~w_deb;
        end else begin : g_any
            assign w_edge = r_prev ^ w_deb;
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_w1c = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    generate
        if (WIDTH < 32) begin : g_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    // A fresh edge wins over a same-cycle W1C on that bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && address == 2'd2) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            r_edgecap <= (r_edgecap & ~w_w1c) | w_edge;
            r_irq     <= |(r_edgecap & r_irqmask);
        end
    end

    always_comb begin
        w_rd = '0;
        unique case (address)
            2'd0: w_rd[WIDTH-1:0] = w_deb;
`ifdef NIOS_PIO_IN_RAW_READ_EN
            2'd1: w_rd[WIDTH-1:0] = w_sync;
`endif
            2'd2: w_rd[WIDTH-1:0] = r_irqmask;
            2'd3: w_rd[WIDTH-1:0] = r_edgecap;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_nios_pio_in_debounce_irq.sv
// Directed bench for nios_pio_in_debounce_irq (WIDTH=4, SYNC=2, DEB=4, falling).
// Expected values are hand-derived from the register-level timing.
module tb_nios_pio_in_debounce_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    nios_pio_in_debounce_irq #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick(1);
        d = readdata;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        tick(3);
        reset_n = 1'b1;
        tick(20);

        // mid-run reset
        wr(2'd2, 32'h3);
        rdreg(2'd2, rd);
        check("mask_pre", rd, 32'h3);
        rdreg(2'd0, rd);
        check("data_pre", rd, 32'hF);
        reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        tick(2);
        address = 2'd0;
        reset_n = 1'b1;
        tick(6);
        check("lat_before", readdata, 32'h0);
        tick(1);
        check("lat_exact", readdata, 32'hF);
        rdreg(2'd2, rd);
        check("rst_mask", rd, 32'h0);
        tick(4);
        rdreg(2'd3, rd);
        check("rst_edgecap", rd, 32'h0);

        // 3-cycle glitch is filtered
        in_port = 4'hE;
        tick(3);
        in_port = 4'hF;
        tick(10);
        rdreg(2'd0, rd);
        check("glitch_data", rd, 32'hF);
        rdreg(2'd3, rd);
        check("glitch_cap", rd, 32'h0);
        in_port = 4'hE;
        tick(10);
        rdreg(2'd0, rd);
        check("press_data", rd, 32'hE);
        rdreg(2'd3, rd);
        check("press_cap", rd, 32'h1);

        // interrupt path
        wr(2'd3, 32'h1);
        in_port = 4'hF;
        tick(10);
        wr(2'd2, 32'h1);
        check("irq_idle", {31'b0, irq}, 32'h0);
        address = 2'd3;
        in_port = 4'hE;
        tick(7);
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_set", {31'b0, irq}, 32'h1);
        check("cap_set", readdata, 32'h1);
        wr(2'd3, 32'h1);
        tick(1);
        check("irq_clr", {31'b0, irq}, 32'h0);
        rdreg(2'd3, rd);
        check("cap_clr", rd, 32'h0);

        // masking
        wr(2'd2, 32'h0);
        in_port = 4'hF;
        tick(10);
        in_port = 4'hD;
        tick(10);
        rdreg(2'd3, rd);
        check("mask_cap", rd, 32'h2);
        check("mask_irq0", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h2);
        check("mask_irq_wait", {31'b0, irq}, 32'h0);
        tick(1);
        check("mask_irq1", {31'b0, irq}, 32'h1);

        // set-wins collision on bit 1
        wr(2'd3, 32'h2);
        in_port = 4'hF;
        tick(10);
        rdreg(2'd3, rd);
        check("coll_pre", rd, 32'h0);
        in_port = 4'hD;
        tick(6);
        wr(2'd3, 32'h2);
        rdreg(2'd3, rd);
        check("coll_cap", rd, 32'h2);
        wr(2'd3, 32'h2);
        rdreg(2'd3, rd);
        check("coll_clr", rd, 32'h0);

        // raw read
        in_port = 4'hA;
        tick(2);
        rdreg(2'd1, rd);
`ifdef NIOS_PIO_IN_RAW_READ_EN
        check("raw_read", rd, 32'hA);
`else
        check("raw_read", rd, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_pio_in_debounce_irq.md
Name: nios_pio_in_debounce_irq

Overview:
- Parametrised successor to the Avalon-MM input-only PIO used for the board push-buttons.
- Signal path per bit:
  - SYNC_STAGES-flop synchroniser
  - per-bit debounce counter
  - edge detector feeding an edge-capture register
  - interrupt mask and level IRQ to the Nios II
- Sits on the lightweight Avalon bus alongside the other PIO slaves; readdata keeps the registered, 1-cycle read latency of the existing PIOs.

Parameters:
- WIDTH, 4: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser depth, minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced value changes; 0 bypasses the debouncer.
- EDGE_TYPE, 1: 0 = rising, 1 = falling (buttons are active-low), 2 = any edge.

Ports:
- clk  in  1  system clock; all registers rise-edge.
- reset_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk externally.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all of the following clear to 0, asynchronously:
  - readdata, irq
  - synchroniser flops, debounce counters, debounced value (deb)
  - edge-detect history
  - irqmask, edgecap
- Register map:
  - 0 data (RO) = deb.
  - 1 raw (RO), see Optional Feature.
  - 2 irqmask (RW), bits [WIDTH-1:0].
  - 3 edgecap (RW1C).
  - Unused upper bits read 0.
- Read:
  - readdata <= zero-extended mux(address) on every clk, regardless of chipselect.
  - Data is valid 1 cycle after address is presented; there are no wait states.
- Write: occurs when chipselect=1 and write_n=0.
  - Address 2: irqmask <= writedata[WIDTH-1:0].
  - Address 3: edgecap[i] cleared for each writedata[i]=1.
  - Addresses 0/1: writes ignored.
- Synchroniser: sync = in_port delayed SYNC_STAGES cycles.
- Debounce, per bit i:
  - If sync[i]==deb[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: deb[i] <= sync[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A mismatch must therefore persist DEBOUNCE_CYCLES consecutive cycles; any glitch back restarts the count.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - DEBOUNCE_CYCLES=0: deb = sync registered one cycle.
- Edge detect: prev <= deb every cycle; edge[i] asserts per EDGE_TYPE from prev[i] and deb[i].
- edgecap[i] <= 1 on edge[i].
  - Simultaneous set and W1C on the same bit: set wins, bit stays 1.
- irq <= |(edgecap & irqmask), registered.
  - irq asserts 1 cycle after edgecap sets, or 1 cycle after a mask write enables an already-captured bit.
- Latency from an in_port change (no bounce) to readdata at address 0: SYNC_STAGES + DEBOUNCE_CYCLES + 1 (readdata reg).
- Reset mid-operation: partial counts are discarded. After release, an input held at 1 produces deb 0->1 after the normal latency. That transition is a genuine edge and is captured if EDGE_TYPE selects rising or any.

Optional Feature:
- Macro: NIOS_PIO_IN_RAW_READ_EN.
- Defined: address 1 returns the zero-extended synchronised, pre-debounce value sync, for diagnostics.
- Undefined: address 1 reads 0, and no raw-path mux logic is generated.
- All other behaviour is identical in both builds.

Test Plan:
All cases use WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=1.
- Reset values: assert reset_n=0 mid-run with in_port=4'hF -> readdata=0, irq=0, irqmask=0, edgecap=0 immediately. After release, data reads 4'hF after 2+4+1 cycles, and no edgecap bits set (rising only).
- Debounce filter: in_port[0] goes 1->0 for 3 cycles, then back to 1 -> data stays 4'hF and edgecap stays 0. Held low for 4+ cycles -> data=4'hE, edgecap=4'h1.
- Interrupt path: irqmask=4'h1, then press bit 0 -> irq=1 one cycle after edgecap[0] sets. Write 4'h1 to address 3 -> edgecap=0 and irq=0 the following cycle.
- Masking: edgecap=4'h2 with irqmask=0 -> irq=0. Write irqmask=4'h2 -> irq=1 one cycle later.
- Set-wins collision: W1C of bit 1 issued in the same cycle a new falling edge on bit 1 is detected -> edgecap[1] remains 1.
- Raw read:
  - Macro defined: drive in_port=4'hA stable 2 cycles, read address 1 -> 4'hA.
  - Macro undefined: address 1 reads 0.
